// File: rtl/des_round_engine_if.sv
// rtl/des_round_engine_if.sv - block in/out handshake bundle for des_round_engine
interface des_round_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_decrypt;
  logic [63:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data_out;

  modport master (
    output in_valid, in_decrypt, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, in_decrypt, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/des_round_engine.sv
// rtl/des_round_engine.sv - iterative DES/3DES data path with key_generator sequencing
// Bit numbering follows the DES tables: table entry 1 is the MSB of the word.
module des_feistel (
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] f
);
  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  // S1..S8, each 4 rows of 16, row = outer bits, column = inner four bits
  localparam logic [3:0] S_T [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  logic [47:0] x;
  logic [5:0]  six;
  logic [8:0]  sidx;
  logic [31:0] s_out;

  always_comb begin
    x     = '0;
    six   = '0;
    sidx  = '0;
    s_out = '0;
    f     = '0;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ subkey;
    for (int b = 0; b < 8; b++) begin
      six  = x[47-6*b -: 6];
      sidx = {b[2:0], six[5], six[0], six[4:1]};
      s_out[31-4*b -: 4] = S_T[sidx];
    end
    for (int i = 0; i < 32; i++) f[31-i] = s_out[32-P_T[i]];
  end
endmodule

module des_round_engine #(
  parameter int PASSES = 3
) (
  input  logic              clk,
  input  logic              rst,
  des_round_engine_if.slave bus,
  output logic              busy,
  input  logic [47:0]       subkey,
  output logic              key_enable,
  output logic [4:0]        round_count,
  output logic [1:0]        key_count,
  output logic              cnt_rollover,
  output logic              key_rollover,
  output logic              reverse
);
  typedef enum logic [2:0] {IDLE, LOAD, PRIME, ROUND, PASS_END, DONE} state_t;

  localparam logic [1:0] LAST_PASS = 2'(PASSES - 1);
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

  function automatic logic [63:0] ip_perm(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[63-i] = d[64-IP_T[i]];
    return o;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[63-i] = d[64-FP_T[i]];
    return o;
  endfunction

  state_t      state, nxt;
  logic [63:0] blk;
  logic [31:0] l, r, f_out;
  logic        mode_q;
  logic [4:0]  rnd;
  logic        last_pass;

  des_feistel u_feistel (
    .r      (r),
    .subkey (subkey),
    .f      (f_out)
  );

  assign last_pass    = (key_count == LAST_PASS);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.data_out  = blk;
  assign busy          = (state != IDLE);
  // key_generator needs the direction before LOAD, so follow the live input while idle
  assign reverse       = (state == IDLE) ? bus.in_decrypt : mode_q;

  always_comb begin
    nxt          = state;
    key_enable   = 1'b0;
    round_count  = 5'd0;
    cnt_rollover = 1'b0;
    key_rollover = 1'b0;
    case (state)
      IDLE:     if (bus.in_valid) nxt = LOAD;
      LOAD: begin
        key_enable = 1'b1;
        nxt        = PRIME;
      end
      PRIME: begin
        key_enable  = 1'b1;
        round_count = 5'd1;
        nxt         = ROUND;
      end
      ROUND: begin
        round_count = rnd + 5'd1;
        key_enable  = (rnd < 5'd16);
        if (rnd == 5'd16) nxt = PASS_END;
      end
      PASS_END: begin
        cnt_rollover = 1'b1;
        key_rollover = last_pass;
        nxt          = last_pass ? DONE : LOAD;
      end
      DONE:     if (bus.out_ready) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      blk       <= '0;
      l         <= '0;
      r         <= '0;
      mode_q    <= 1'b0;
      key_count <= 2'd0;
      rnd       <= 5'd0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            blk       <= bus.data_in;
            mode_q    <= bus.in_decrypt;
            key_count <= 2'd0;
          end
        end
        LOAD:  {l, r} <= ip_perm(blk);
        PRIME: rnd <= 5'd1;
        ROUND: begin
          l   <= r;
          r   <= l ^ f_out;
          rnd <= rnd + 5'd1;
        end
        PASS_END: begin
          blk       <= fp_perm({r, l});
          key_count <= last_pass ? 2'd0 : key_count + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_des_round_engine.sv
// tb/tb_des_round_engine.sv - directed bench for des_round_engine with a key_generator stand-in
module tb_des_round_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [47:0] subkey;
  logic        key_enable;
  logic [4:0]  round_count;
  logic [1:0]  key_count;
  logic        cnt_rollover;
  logic        key_rollover;
  logic        reverse;
  int          checks = 0;
  int          failures = 0;
  bit          distinct = 1'b0;

  localparam logic [63:0] PT = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CT = 64'h85E8_1354_0F0A_B405;
  // subkeys of key 133457799BBCDFF1
  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
  localparam logic [47:0] PMASK [3] = '{48'h0, 48'h5A5A_0F0F_3C3C, 48'hC3C3_A5A5_9696};

  always #5 clk = ~clk;

  des_round_engine_if bus ();

  des_round_engine #(.PASSES(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .subkey       (subkey),
    .key_enable   (key_enable),
    .round_count  (round_count),
    .key_count    (key_count),
    .cnt_rollover (cnt_rollover),
    .key_rollover (key_rollover),
    .reverse      (reverse)
  );

  // EDE schedule: middle pass runs opposite direction; decrypt walks the pass keys backwards
  function automatic logic [47:0] key_model(input logic rev, input logic [1:0] kc, input logic [4:0] rc);
    int  pidx, kidx;
    logic dir;
    pidx = rev ? 2 - int'(kc) : int'(kc);
    dir  = rev ^ (kc == 2'd1);
    kidx = dir ? 16 - int'(rc) : int'(rc) - 1;
    return KS[kidx] ^ (distinct ? PMASK[pidx] : 48'h0);
  endfunction

  initial subkey = '0;
  always @(posedge clk)
    if (key_enable && round_count >= 5'd1 && round_count <= 5'd16)
      subkey <= key_model(reverse, key_count, round_count);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [63:0] d, input logic dec, output logic [63:0] res, output bit timeout);
    int n;
    bus.data_in    = d;
    bus.in_decrypt = dec;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    timeout = !bus.out_valid;
    res     = bus.data_out;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_decrypt = 1'b1; bus.data_in = '0; bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake got in_ready=%b out_valid=%b busy=%b exp 1 0 0", bus.in_ready, bus.out_valid, busy);
    end
    checks++;
    if (key_enable !== 1'b0 || round_count !== 5'd0 || key_count !== 2'd0 || cnt_rollover !== 1'b0 || key_rollover !== 1'b0) begin
      failures++;
      $display("FAIL reset_key_outputs got ke=%b rc=%0d kc=%0d cr=%b kr=%b exp all zero", key_enable, round_count, key_count, cnt_rollover, key_rollover);
    end
    checks++;
    if (bus.data_out !== 64'h0 || reverse !== 1'b1) begin
      failures++;
      $display("FAIL reset_data_reverse got data_out=%h reverse=%b exp 0 1", bus.data_out, reverse);
    end
    bus.in_decrypt = 1'b0;
  endtask

  task automatic test_sequencing;
    distinct = 1'b0;
    bus.data_in = PT; bus.in_decrypt = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 57; k++) begin
      int p, o;
      logic ek, ecr, ekr;
      logic [4:0] erc;
      p   = k / 19;
      o   = k % 19;
      ek  = (o <= 16);
      erc = (o == 18) ? 5'd0 : 5'(o);
      ecr = (o == 18);
      ekr = (o == 18) && (p == 2);
      checks++;
      if (key_enable !== ek || round_count !== erc || cnt_rollover !== ecr || key_rollover !== ekr || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL seq_edge%0d got ke=%b rc=%0d cr=%b kr=%b busy=%b ir=%b exp ke=%b rc=%0d cr=%b kr=%b busy=1 ir=0",
                 k, key_enable, round_count, cnt_rollover, key_rollover, busy, bus.in_ready, ek, erc, ecr, ekr);
      end
      if (o == 18) begin
        checks++;
        if (key_count !== p[1:0]) begin
          failures++;
          $display("FAIL seq_pass_end_key_count got=%0d exp=%0d", key_count, p);
        end
      end
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== CT) begin
      failures++;
      $display("FAIL seq_edge57_result got out_valid=%b data_out=%h exp 1 %h", bus.out_valid, bus.data_out, CT);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_return_idle got in_ready=%b out_valid=%b exp 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_known_decrypt;
    logic [63:0] res;
    bit to;
    distinct = 1'b0;
    run_block(CT, 1'b1, res, to);
    checks++;
    if (to || res !== PT) begin
      failures++;
      $display("FAIL known_decrypt got=%h timeout=%b exp=%h", res, to, PT);
    end
  endtask

  task automatic test_round_trip;
    logic [63:0] vec [19];
    logic [63:0] ct, pt;
    bit to1, to2;
    distinct = 1'b1;
    vec[0] = PT; vec[1] = 64'h0; vec[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 3; i < 19; i++) vec[i] = {$urandom, $urandom};
    for (int i = 0; i < 19; i++) begin
      run_block(vec[i], 1'b0, ct, to1);
      run_block(ct, 1'b1, pt, to2);
      checks++;
      if (to1 || to2 || pt !== vec[i] || ct === vec[i]) begin
        failures++;
        $display("FAIL round_trip%0d got ct=%h pt=%h timeout=%b%b exp pt=%h", i, ct, pt, to1, to2, vec[i]);
      end
    end
    distinct = 1'b0;
  endtask

  task automatic test_back_pressure;
    logic [63:0] res;
    int n;
    bit to;
    distinct = 1'b0;
    bus.data_in = PT; bus.in_decrypt = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.out_valid) begin
      failures++;
      $display("FAIL bp_out_valid_timeout got out_valid=0 exp 1");
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (bus.data_out !== CT || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d got data_out=%h in_ready=%b out_valid=%b exp %h 0 1", c, bus.data_out, bus.in_ready, bus.out_valid, CT);
      end
    end
    bus.out_ready = 1'b1;
    bus.data_in = CT; bus.in_decrypt = 1'b1; bus.in_valid = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release_idle got in_ready=%b out_valid=%b exp 1 0", bus.in_ready, bus.out_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_next_accept got busy=%b in_ready=%b exp 1 0", busy, bus.in_ready);
    end
    n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    to  = !bus.out_valid;
    res = bus.data_out;
    tick();
    checks++;
    if (to || res !== PT) begin
      failures++;
      $display("FAIL bp_second_block got=%h timeout=%b exp=%h", res, to, PT);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] res;
    bit to;
    distinct = 1'b1;
    bus.data_in = PT; bus.in_decrypt = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (27) tick();
    checks++;
    if (key_count !== 2'd1 || round_count !== 5'd8) begin
      failures++;
      $display("FAIL mid_position got kc=%0d rc=%0d exp 1 8", key_count, round_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || key_count !== 2'd0 || busy !== 1'b0 || bus.data_out !== 64'h0) begin
      failures++;
      $display("FAIL mid_reset got ir=%b ov=%b kc=%0d busy=%b data_out=%h exp 1 0 0 0 0",
               bus.in_ready, bus.out_valid, key_count, busy, bus.data_out);
    end
    distinct = 1'b0;
    run_block(PT, 1'b0, res, to);
    checks++;
    if (to || res !== CT) begin
      failures++;
      $display("FAIL mid_after_reset got=%h timeout=%b exp=%h", res, to, CT);
    end
  endtask

  task automatic test_ignored_input;
    logic [63:0] res;
    int n, extra;
    distinct = 1'b0;
    bus.data_in = CT; bus.in_decrypt = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    n = 0;
    while (!bus.out_valid && n < 200) begin
      bus.in_valid   = ~bus.in_valid;
      bus.data_in    = {$urandom, $urandom};
      bus.in_decrypt = $urandom_range(0, 1);
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    res = bus.data_out;
    checks++;
    if (!bus.out_valid || res !== PT) begin
      failures++;
      $display("FAIL ignore_result got=%h out_valid=%b exp=%h", res, bus.out_valid, PT);
    end
    tick();
    extra = 0;
    for (int c = 0; c < 70; c++) begin
      if (bus.out_valid) extra++;
      tick();
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL ignore_extra_transfers got=%0d exp=0", extra);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequencing();
    test_known_decrypt();
    test_round_trip();
    test_back_pressure();
    test_reset_mid();
    test_ignored_input();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
